// File: rtl/csi2_pkg.sv
// Shared types, constants and helper functions for the CSI-2 packet parser.
package csi2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CRC,
    ST_FLUSH
  } state_e;

  // Data type codes for the synchronisation short packets
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  // Data types at or above this value are long packets
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  // Header parity masks over {WC MSB, WC LSB, DI}; entry i produces ECC bit i
  localparam logic [5:0][23:0] ECC_MASKS = {
    24'hEFFC00,
    24'hDF03F0,
    24'hB8E38E,
    24'h749A6D,
    24'hF2555B,
    24'hF12CB7
  };

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  // 6-bit header ECC of the 24 header bits
  function automatic logic [5:0] ecc6(input logic [23:0] hdr);
    logic [5:0] p;
    for (int i = 0; i < 6; i++) begin
      p[i] = ^(hdr & ECC_MASKS[i]);
    end
    return p;
  endfunction

  // One byte of the reflected CRC-16, LSB of the byte first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Byte-enabled CRC-16 accumulator, four bytes per cycle, lane 0 first.
// crc_o is the updated value including this cycle's enabled bytes, so the
// caller can compare against a checksum arriving in the same word.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        byte_clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  keep_i,
  input  logic        init_i,
  input  logic        enable_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Fold the kept bytes into either the seed or the running value
  always_comb begin
    crc_d = init_i ? CRC_SEED : crc_q;
    if (enable_i) begin
      for (int b = 0; b < 4; b++) begin
        if (keep_i[b]) begin
          crc_d = crc16_byte(crc_d, data_i[8*b +: 8]);
        end
      end
    end
  end

  assign crc_o = crc_d;

  // Running CRC register
  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) begin
      crc_q <= CRC_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser: header ECC check, short-packet sync decode, payload
// streaming with byte keep, and trailing CRC-16 check. All outputs registered,
// one cycle after the word that produced them.
module csi2_pkt_parser
  import csi2_pkg::*;
#(
  parameter int DATA_LANES = 4
) (
  input  logic                       byte_clk_i,
  input  logic                       rst_n_i,
  input  logic [DATA_LANES-1:0][7:0] word_i,
  input  logic                       valid_i,
  output logic                       eop_o,
  output logic                       hdr_valid_o,
  output logic [1:0]                 pkt_vc_o,
  output logic [5:0]                 pkt_dt_o,
  output logic [15:0]                pkt_wc_o,
  output logic                       frame_start_o,
  output logic                       frame_end_o,
  output logic                       line_start_o,
  output logic                       line_end_o,
  output logic [31:0]                tdata_o,
  output logic [3:0]                 tkeep_o,
  output logic                       tvalid_o,
  output logic                       tlast_o,
  output logic                       ecc_err_o,
  output logic                       crc_err_o
);

  if (DATA_LANES != 4) begin : g_lane_check
    $error("csi2_pkt_parser: DATA_LANES must be 4");
  end

  logic [3:0][7:0] w;
  assign w = word_i;

  // Header fields as seen on the current word
  logic [23:0] hdr_bits;
  logic [7:0]  hdr_ecc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        ecc_ok;

  assign hdr_bits = w[2:0];
  assign hdr_ecc  = w[3];
  assign hdr_dt   = w[0][5:0];
  assign hdr_wc   = {w[2], w[1]};
  assign ecc_ok   = (hdr_ecc == {2'b00, ecc6(hdr_bits)});

  // Control state
  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic        need1_q, need1_d;
  logic [7:0]  lsb_q, lsb_d;

  // Registered outputs
  logic        eop_q, eop_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        ecc_err_q, ecc_err_d;
  logic        crc_err_q, crc_err_d;

  // CRC engine hookup
  logic        crc_init;
  logic        crc_en;
  logic [3:0]  crc_keep;
  logic [15:0] crc_val;

  // Last-beat helpers: keep mask and checksum lanes when rem <= 4
  logic [3:0]  keep_last;
  logic [1:0]  lane_lo;
  logic [1:0]  lane_hi;

  assign keep_last = (rem_q[2:0] == 3'd4) ? 4'hF : ((4'd1 << rem_q[1:0]) - 4'd1);
  assign lane_lo   = rem_q[1:0];
  assign lane_hi   = rem_q[1:0] + 2'd1;

  csi2_crc16 u_crc (
    .byte_clk_i (byte_clk_i),
    .rst_n_i    (rst_n_i),
    .data_i     (w),
    .keep_i     (crc_keep),
    .init_i     (crc_init),
    .enable_i   (crc_en),
    .crc_o      (crc_val)
  );

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    need1_d     = need1_q;
    lsb_d       = lsb_q;
    eop_d       = 1'b0;
    hdr_valid_d = 1'b0;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    fs_d        = 1'b0;
    fe_d        = 1'b0;
    ls_d        = 1'b0;
    le_d        = 1'b0;
    tdata_d     = 32'h0;
    tkeep_d     = 4'h0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    ecc_err_d   = 1'b0;
    crc_err_d   = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_keep    = 4'h0;

    case (state_q)
      ST_IDLE: begin
        crc_init = 1'b1;
        if (valid_i) begin
          if (!ecc_ok) begin
            ecc_err_d = 1'b1;
            eop_d     = 1'b1;
            state_d   = ST_FLUSH;
          end else begin
            hdr_valid_d = 1'b1;
            vc_d        = w[0][7:6];
            dt_d        = hdr_dt;
            wc_d        = hdr_wc;
            if (hdr_dt < DT_LONG_MIN) begin
              fs_d    = (hdr_dt == DT_FS);
              fe_d    = (hdr_dt == DT_FE);
              ls_d    = (hdr_dt == DT_LS);
              le_d    = (hdr_dt == DT_LE);
              eop_d   = 1'b1;
              state_d = ST_FLUSH;
            end else if (hdr_wc == 16'd0) begin
              need1_d = 1'b0;
              state_d = ST_CRC;
            end else begin
              rem_d   = hdr_wc;
              state_d = ST_PAYLOAD;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (!valid_i) begin
          // Truncated: close the stream with an empty last beat
          tvalid_d  = 1'b1;
          tlast_d   = 1'b1;
          crc_err_d = 1'b1;
          eop_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          crc_en   = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = w;
          if (rem_q > 16'd4) begin
            tkeep_d  = 4'hF;
            crc_keep = 4'hF;
            rem_d    = rem_q - 16'd4;
          end else begin
            tkeep_d  = keep_last;
            crc_keep = keep_last;
            tlast_d  = 1'b1;
            if (rem_q <= 16'd2) begin
              crc_err_d = (crc_val != {w[lane_hi], w[lane_lo]});
              eop_d     = 1'b1;
              state_d   = ST_FLUSH;
            end else begin
              // rem 3: LSB in lane 3, MSB next word; rem 4: both next word
              need1_d = (rem_q == 16'd3);
              lsb_d   = w[3];
              state_d = ST_CRC;
            end
          end
        end
      end

      ST_CRC: begin
        if (!valid_i) begin
          // A zero-length long packet never issued tlast
          if (wc_q == 16'd0) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
          end
          crc_err_d = 1'b1;
          eop_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          crc_err_d = need1_q ? (crc_val != {w[0], lsb_q}) : (crc_val != {w[1], w[0]});
          eop_d     = 1'b1;
          state_d   = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (!valid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      rem_q       <= 16'h0;
      need1_q     <= 1'b0;
      lsb_q       <= 8'h0;
      eop_q       <= 1'b0;
      hdr_valid_q <= 1'b0;
      vc_q        <= 2'h0;
      dt_q        <= 6'h0;
      wc_q        <= 16'h0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ls_q        <= 1'b0;
      le_q        <= 1'b0;
      tdata_q     <= 32'h0;
      tkeep_q     <= 4'h0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      ecc_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      need1_q     <= need1_d;
      lsb_q       <= lsb_d;
      eop_q       <= eop_d;
      hdr_valid_q <= hdr_valid_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      fs_q        <= fs_d;
      fe_q        <= fe_d;
      ls_q        <= ls_d;
      le_q        <= le_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      ecc_err_q   <= ecc_err_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign eop_o         = eop_q;
  assign hdr_valid_o   = hdr_valid_q;
  assign pkt_vc_o      = vc_q;
  assign pkt_dt_o      = dt_q;
  assign pkt_wc_o      = wc_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign line_start_o  = ls_q;
  assign line_end_o    = le_q;
  assign tdata_o       = tdata_q;
  assign tkeep_o       = tkeep_q;
  assign tvalid_o      = tvalid_q;
  assign tlast_o       = tlast_q;
  assign ecc_err_o     = ecc_err_q;
  assign crc_err_o     = crc_err_q;

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Bench for csi2_pkt_parser: packets are built from byte lists, the expected
// output of every cycle is derived from the packet rules and queued, and one
// process compares the DUT against that queue each cycle.
module tb_csi2_pkt_parser;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][7:0] word;
  logic            valid;

  logic        eop_o, hdr_valid_o, frame_start_o, frame_end_o, line_start_o, line_end_o;
  logic [1:0]  pkt_vc_o;
  logic [5:0]  pkt_dt_o;
  logic [15:0] pkt_wc_o;
  logic [31:0] tdata_o;
  logic [3:0]  tkeep_o;
  logic        tvalid_o, tlast_o, ecc_err_o, crc_err_o;

  always #5 clk = ~clk;

  csi2_pkt_parser #(.DATA_LANES(4)) dut (
    .byte_clk_i    (clk),
    .rst_n_i       (rst_n),
    .word_i        (word),
    .valid_i       (valid),
    .eop_o         (eop_o),
    .hdr_valid_o   (hdr_valid_o),
    .pkt_vc_o      (pkt_vc_o),
    .pkt_dt_o      (pkt_dt_o),
    .pkt_wc_o      (pkt_wc_o),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o),
    .line_start_o  (line_start_o),
    .line_end_o    (line_end_o),
    .tdata_o       (tdata_o),
    .tkeep_o       (tkeep_o),
    .tvalid_o      (tvalid_o),
    .tlast_o       (tlast_o),
    .ecc_err_o     (ecc_err_o),
    .crc_err_o     (crc_err_o)
  );

  typedef struct packed {
    logic        eop;
    logic        hdr;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        fs, fe, ls, le;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast, ecc_err, crc_err;
  } rec_t;

  rec_t        expq[$];
  rec_t        exp_r, act_r;
  int          checks = 0;
  int          errors = 0;

  // Model's view of the held packet fields
  logic [1:0]  m_vc;
  logic [5:0]  m_dt;
  logic [15:0] m_wc;

  logic [7:0]  pl[$];
  logic [31:0] pin_tdata[$];
  logic [3:0]  pin_tkeep[$];
  logic        pin_tlast[$];
  int          last_nwords;

  int          r_kind;
  logic [15:0] r_wc;
  logic [5:0]  r_dt;
  logic [31:0] r_flip;
  logic [15:0] r_cxor;
  bit          r_trunc;
  int          r_extra;

  // Header ECC from the parity equations of the CSI-2 Hamming code
  function automatic logic [5:0] m_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Bit-serial reflected CRC-16 over a byte list
  function automatic logic [15:0] m_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r    = '0;
    r.vc = m_vc;
    r.dt = m_dt;
    r.wc = m_wc;
    return r;
  endfunction

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // One clock of stimulus plus the outputs expected after that edge
  task automatic drive(input logic r, input logic v, input logic [31:0] w, input rec_t e);
    @(negedge clk);
    rst_n = r;
    valid = v;
    word  = w;
    expq.push_back(e);
  endtask

  task automatic tail(input int extra);
    for (int i = 0; i < extra; i++) drive(1'b1, 1'b1, $urandom, idle_rec());
    drive(1'b1, 1'b0, $urandom, idle_rec());
  endtask

  // Send one packet (payload taken from pl) and queue its expected outputs
  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input logic [31:0] flip, input logic [15:0] cxor, input bit trunc,
                          input int rst_k, input int extra);
    logic [31:0] hw, w;
    logic [15:0] crcv, crc_rx;
    logic [7:0]  s[$];
    int          beats, nwords, rlast, tk;
    rec_t        e;
    pin_tdata.delete();
    pin_tkeep.delete();
    pin_tlast.delete();
    hw = {2'b00, m_ecc({wc, vc, dt}), wc, vc, dt} ^ flip;
    if (hw[31:24] != {2'b00, m_ecc(hw[23:0])}) begin
      e = idle_rec();
      e.ecc_err = 1'b1;
      e.eop     = 1'b1;
      drive(1'b1, 1'b1, hw, e);
      tail(extra);
      return;
    end
    m_vc = hw[7:6];
    m_dt = hw[5:0];
    m_wc = hw[23:8];
    e = idle_rec();
    e.hdr = 1'b1;
    if (m_dt < 6'h10) begin
      e.fs  = (m_dt == 6'h00);
      e.fe  = (m_dt == 6'h01);
      e.ls  = (m_dt == 6'h02);
      e.le  = (m_dt == 6'h03);
      e.eop = 1'b1;
      drive(1'b1, 1'b1, hw, e);
      tail(extra);
      return;
    end
    drive(1'b1, 1'b1, hw, e);
    crcv   = m_crc(pl);
    crc_rx = crcv ^ cxor;
    s = pl;
    s.push_back(crc_rx[7:0]);
    s.push_back(crc_rx[15:8]);
    while (s.size() % 4 != 0) s.push_back(8'($urandom));
    beats       = (int'(wc) + 3) / 4;
    nwords      = s.size() / 4;
    rlast       = int'(wc) - 4 * (beats - 1);
    tk          = trunc ? $urandom_range(0, nwords - 1) : nwords;
    last_nwords = nwords;
    for (int k = 0; k < tk; k++) begin
      w = {s[4*k+3], s[4*k+2], s[4*k+1], s[4*k]};
      if (k == rst_k) begin
        m_vc = '0;
        m_dt = '0;
        m_wc = '0;
        drive(1'b0, 1'b1, w, '0);
        drive(1'b1, 1'b0, 32'h0, idle_rec());
        return;
      end
      e = idle_rec();
      if (k < beats) begin
        e.tvalid = 1'b1;
        e.tdata  = w;
        e.tlast  = (k == beats - 1);
        e.tkeep  = e.tlast ? 4'((1 << rlast) - 1) : 4'hF;
        pin_tdata.push_back(e.tdata);
        pin_tkeep.push_back(e.tkeep);
        pin_tlast.push_back(e.tlast);
      end
      if (k == nwords - 1) begin
        e.crc_err = (crc_rx != crcv);
        e.eop     = 1'b1;
      end
      drive(1'b1, 1'b1, w, e);
    end
    if (tk < nwords) begin
      e = idle_rec();
      if (tk < beats || beats == 0) begin
        e.tvalid = 1'b1;
        e.tlast  = 1'b1;
      end
      e.crc_err = 1'b1;
      e.eop     = 1'b1;
      drive(1'b1, 1'b0, $urandom, e);
    end else begin
      tail(extra);
    end
  endtask

  task automatic fill_pl(input int n, input bit ramp);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(ramp ? 8'(i + 1) : 8'($urandom));
  endtask

  // Cycle-by-cycle comparison against the expected queue
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        exp_r = expq.pop_front();
        act_r = {eop_o, hdr_valid_o, pkt_vc_o, pkt_dt_o, pkt_wc_o,
                 frame_start_o, frame_end_o, line_start_o, line_end_o,
                 tdata_o, tkeep_o, tvalid_o, tlast_o, ecc_err_o, crc_err_o};
        checks++;
        if (act_r !== exp_r) begin
          errors++;
          $display("FAIL cycle t=%0t got %h want %h (eop,hdr,vc,dt,wc,fs,fe,ls,le,tdata,tkeep,tvalid,tlast,ecc,crc)",
                   $time, act_r, exp_r);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    word  = '0;
    m_vc  = '0;
    m_dt  = '0;
    m_wc  = '0;

    // Pin the reference model with hand-computed values
    pin("ecc_zero", 32'(m_ecc(24'h000000)), 32'h00);
    pin("ecc_d0",   32'(m_ecc(24'h000001)), 32'h07);
    pin("ecc_d23",  32'(m_ecc(24'h800000)), 32'h3B);
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
    pin("crc_check", 32'(m_crc(pl)), 32'h6F91);

    // Reset phase
    repeat (3) drive(1'b0, 1'b0, $urandom, '0);
    drive(1'b1, 1'b0, 32'h0, idle_rec());

    // Frame start, WC=0, ECC 0
    pl.delete();
    send_pkt(2'd0, 6'h00, 16'd0, 32'h0, 16'h0, 1'b0, -1, 0);

    // Long packet, six ramp bytes
    fill_pl(6, 1'b1);
    send_pkt(2'd0, 6'h2A, 16'd6, 32'h0, 16'h0, 1'b0, -1, 0);
    pin("wc6_beats", 32'(pin_tdata.size()), 32'd2);
    pin("wc6_b0_data", pin_tdata[0], 32'h04030201);
    pin("wc6_b0_keep", 32'(pin_tkeep[0]), 32'hF);
    pin("wc6_b1_data", 32'(pin_tdata[1][15:0]), 32'h0605);
    pin("wc6_b1_keep", 32'(pin_tkeep[1]), 32'h3);
    pin("wc6_b1_last", 32'(pin_tlast[1]), 32'h1);

    // WC=3: checksum split over two words
    fill_pl(3, 1'b0);
    send_pkt(2'd1, 6'h2B, 16'd3, 32'h0, 16'h0, 1'b0, -1, 0);
    pin("wc3_words", 32'(last_nwords), 32'd2);
    pin("wc3_keep", 32'(pin_tkeep[0]), 32'h7);

    // Corrupted header, then a normal packet
    pl.delete();
    send_pkt(2'd0, 6'h00, 16'd0, 32'h1, 16'h0, 1'b0, -1, 0);
    fill_pl(6, 1'b1);
    send_pkt(2'd2, 6'h2A, 16'd6, 32'h0, 16'h0, 1'b0, -1, 1);

    // Checksum error with payload intact
    fill_pl(6, 1'b1);
    send_pkt(2'd0, 6'h2A, 16'd6, 32'h0, 16'h0001, 1'b0, -1, 0);

    // Reset in the middle of a 64-byte payload, then a frame start
    fill_pl(64, 1'b0);
    send_pkt(2'd3, 6'h24, 16'd64, 32'h0, 16'h0, 1'b0, 5, 0);
    pl.delete();
    send_pkt(2'd0, 6'h00, 16'd0, 32'h0, 16'h0, 1'b0, -1, 0);

    // Other sync short packets
    send_pkt(2'd1, 6'h01, 16'h1234, 32'h0, 16'h0, 1'b0, -1, 0);
    send_pkt(2'd2, 6'h02, 16'h0007, 32'h0, 16'h0, 1'b0, -1, 0);
    send_pkt(2'd3, 6'h03, 16'hBEEF, 32'h0, 16'h0, 1'b0, -1, 0);

    // Randomised traffic
    for (int n = 0; n < 200; n++) begin
      r_kind  = $urandom_range(0, 9);
      r_flip  = ($urandom_range(0, 9) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      r_cxor  = ($urandom_range(0, 6) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
      r_trunc = ($urandom_range(0, 9) == 0);
      r_extra = $urandom_range(0, 2);
      if (r_kind < 2) begin
        r_dt = 6'($urandom_range(0, 15));
        r_wc = 16'($urandom);
        pl.delete();
      end else begin
        r_dt = 6'($urandom_range(16, 63));
        r_wc = (r_kind == 2) ? 16'd0 : 16'($urandom_range(1, 24));
        fill_pl(int'(r_wc), 1'b0);
      end
      send_pkt(2'($urandom), r_dt, r_wc, r_flip, r_cxor, r_trunc, -1, r_extra);
    end

    repeat (3) drive(1'b1, 1'b0, 32'h0, idle_rec());
    @(posedge clk);
    #4;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0 pending", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi2_pkt_parser.md
CSI2_PKT_PARSER -- requirements
Module: csi2_pkt_parser

Interface
REQ-001 Parameter DATA_LANES, default 4, number of D-PHY data lanes; only the value 4 is legal, and any other value SHALL fail elaboration.
REQ-002 byte_clk_i  input  1  byte clock; single clock domain for the whole block.
REQ-003 rst_n_i  input  1  reset; synchronous, active-low.
REQ-004 word_i  input  [DATA_LANES-1:0][7:0]  lane-aligned word from the word aligner; lane 0 carries the earliest byte.
REQ-005 valid_i  input  1  word_i is valid; high continuously for the duration of a packet.
REQ-006 eop_o  output  1  one-cycle end-of-packet pulse back to the aligner.
REQ-007 hdr_valid_o  output  1  one-cycle pulse; pkt_vc_o, pkt_dt_o and pkt_wc_o are valid.
REQ-008 pkt_vc_o / pkt_dt_o / pkt_wc_o  output  2 / 6 / 16  virtual channel, data type and word count of the current packet.
REQ-009 frame_start_o / frame_end_o / line_start_o / line_end_o  output  1 each  one-cycle pulses for short packets with DT 0x00 / 0x01 / 0x02 / 0x03.
REQ-010 tdata_o / tkeep_o / tvalid_o / tlast_o  output  32 / 4 / 1 / 1  payload stream; there is no backpressure.
REQ-011 ecc_err_o / crc_err_o  output  1 each  one-cycle error pulses.

Function
REQ-012 Header byte order SHALL be: lane 0 = DI (VC in [7:6], DT in [5:0]), lane 1 = WC LSB, lane 2 = WC MSB, lane 3 = ECC.
REQ-013 The FSM SHALL have the states IDLE, PAYLOAD, CRC and FLUSH.
REQ-014 IDLE: on the first cycle with valid_i=1, the block SHALL register the header and compute the 6-bit CSI-2 ECC over the 24 header bits; ECC[7:6] SHALL be compared to 0.
REQ-015 ECC mismatch: ecc_err_o SHALL pulse, hdr_valid_o SHALL stay low, and the FSM SHALL go to FLUSH; no error correction is performed.
REQ-016 ECC ok: hdr_valid_o SHALL pulse one cycle after the header word.
- DT<0x10: short packet; the matching sync pulse (if DT<=0x03) SHALL fire together with hdr_valid_o, and the FSM SHALL go to FLUSH.
- Long packet with WC=0: next state SHALL be CRC, expecting 2 checksum bytes.
- Otherwise: next state SHALL be PAYLOAD with rem=WC.
REQ-017 PAYLOAD: each valid_i word SHALL produce one tvalid_o beat one cycle later, with tdata_o=word_i and rem decremented by 4.
- When rem<=4: tlast_o=1 and tkeep_o=(1<<rem)-1.
- The checksum bytes then start at lane rem. If rem<=2, both checksum bytes lie in the same word and the FSM SHALL go to FLUSH. Otherwise the remaining (rem-2) checksum bytes arrive in the next word and the FSM SHALL go to CRC.
REQ-018 CRC state: the block SHALL take the remaining checksum byte(s) from lanes 0..n-1 of the next valid word, then go to FLUSH.
REQ-019 Checksum rules:
- CRC-16 CCITT, reflected polynomial 0x8408, seed 0xFFFF, applied only to bytes with tkeep=1.
- The received checksum is LSB first.
- A mismatch SHALL pulse crc_err_o in the cycle the final checksum byte is evaluated, no later than 2 cycles after tlast_o.
- WC=0 SHALL compare against 0xFFFF.
REQ-020 eop_o SHALL pulse exactly once per packet, in the cycle the FSM enters FLUSH.
REQ-021 FLUSH: the block SHALL ignore word_i and return to IDLE on the first cycle with valid_i=0.
REQ-022 valid_i dropping in PAYLOAD or CRC (truncated packet): the block SHALL pulse tlast_o with tkeep_o=0 if no tlast_o was issued, pulse crc_err_o and eop_o, and go to IDLE.
REQ-023 valid_i gaps are not supported; a gap SHALL be treated as truncation per REQ-022.
REQ-024 Error pulses and eop_o may coincide; all SHALL be asserted in that case.
REQ-025 pkt_* outputs SHALL hold their values until the next hdr_valid_o.

Reset
REQ-026 While rst_n_i=0 at a clock edge, the FSM SHALL return to IDLE and all outputs SHALL be 0, including pkt_* and tdata_o; the CRC register SHALL be 0xFFFF.
REQ-027 Reset mid-packet SHALL abort the packet without emitting eop_o or tlast_o; after reset the next valid_i word SHALL be parsed as a header.

Structure
REQ-028 Package csi2_pkg SHALL hold the FSM state enum, the DT constants (FS=0x00, FE=0x01, LS=0x02, LE=0x03, short/long boundary 0x10), the six ECC parity masks, CRC_POLY=16'h8408 and CRC_SEED=16'hFFFF.
REQ-029 Sub-module csi2_crc16 SHALL implement the byte-enabled 4-byte-per-cycle CRC update (inputs: data, keep, init, enable; output: crc).

Verification
REQ-030 Header 0x00,0x00,0x00,0x00 (FS, WC=0, ECC=0x00) -> hdr_valid_o and frame_start_o pulse together, eop_o pulses, tvalid_o stays 0.
REQ-031 DT=0x2A, WC=6, payload 01..06, correct checksum -> beats 0x04030201 with tkeep 1111, then 0x__ __ 06 05 with tkeep 0011 and tlast; crc_err_o=0; one eop_o pulse.
REQ-032 WC=3, correct checksum split across 2 words -> one beat with tkeep 0111 and tlast; CRC state entered; eop_o pulses after the second word; crc_err_o=0.
REQ-033 FS header with DI bit 0 flipped -> ecc_err_o pulses, no hdr_valid_o, eop_o pulses, the next packet parses normally.
REQ-034 Case of REQ-031 with checksum XOR 0x0001 -> crc_err_o pulses, payload is still delivered intact.
REQ-035 rst_n_i=0 for 1 cycle mid-PAYLOAD of WC=64 -> all outputs 0, no eop_o, and the following FS packet is parsed correctly.
